// File: rtl/alarm_trigger_pkg.sv
// Shared types and defaults for the alarm trigger, its tone generator and the
// display/top-level logic that reuses the ring and snooze timing values.
package alarm_trigger_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2
  } alarm_state_t;

  localparam logic [3:0] BCD_ZERO = 4'd0;

  localparam int DEF_TONE_DIV    = 500;
  localparam int DEF_RING_SECS   = 60;
  localparam int DEF_SNOOZE_SECS = 300;
  localparam int DEF_MAX_SNOOZE  = 3;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Only 00..23 in BCD is a real hour; anything else must never match.
  function automatic logic bcd_hour_valid(input logic [3:0] tens, input logic [3:0] ones);
    return ((tens < 4'd2) && (ones <= 4'd9)) || ((tens == 4'd2) && (ones <= 4'd3));
  endfunction

endpackage

// File: rtl/alarm_tone_gen.sv
// Square-wave tone source: toggles every TONE_DIV clocks while enabled and
// restarts from a known phase (divider 0, tone low) whenever disabled.
module alarm_tone_gen
  import alarm_trigger_pkg::*;
#(
  parameter int TONE_DIV = DEF_TONE_DIV
) (
  input  logic clk,
  input  logic CLR_n,
  input  logic en,
  output logic tone
);

  localparam int DIV_W = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TONE_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             tone_q, tone_d;

  always_comb begin
    div_d  = div_q;
    tone_d = tone_q;
    if (!en) begin
      div_d  = '0;
      tone_d = 1'b0;
    end else if (div_q == DIV_LAST) begin
      div_d  = '0;
      tone_d = ~tone_q;
    end else begin
      div_d = div_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or posedge CLR_n) begin
    if (CLR_n) begin
      div_q  <= '0;
      tone_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      tone_q <= tone_d;
    end
  end

  assign tone = tone_q;

endmodule

// File: rtl/alarm_trigger.sv
// Alarm sequencer: fires at HH:00:00 of the set hour, then handles ringing,
// snooze and auto-timeout, and drives the buzzer and status outputs.
module alarm_trigger
  import alarm_trigger_pkg::*;
#(
  parameter int TONE_DIV    = DEF_TONE_DIV,
  parameter int RING_SECS   = DEF_RING_SECS,
  parameter int SNOOZE_SECS = DEF_SNOOZE_SECS,
  parameter int MAX_SNOOZE  = DEF_MAX_SNOOZE
) (
  input  logic       clk,
  input  logic       CLR_n,
  input  logic       sec_tick,
  input  logic [3:0] cur_hour_tens,
  input  logic [3:0] cur_hour_ones,
  input  logic [3:0] cur_min_tens,
  input  logic [3:0] cur_min_ones,
  input  logic [3:0] cur_sec_tens,
  input  logic [3:0] cur_sec_ones,
  input  logic [3:0] alarm_hour_setting_tens,
  input  logic [3:0] alarm_hour_setting_ones,
  input  logic       alarm_enable,
  input  logic       isSettingAlarm,
  input  logic       stop_btn,
  input  logic       snooze_btn,
  output logic       buzzer,
  output logic       ringing,
  output logic       snoozing,
  output logic [1:0] snooze_cnt
);

  localparam int SEC_W = $clog2(max_int(RING_SECS, SNOOZE_SECS) + 1);
  localparam logic [SEC_W-1:0] RING_LAST   = SEC_W'(RING_SECS - 1);
  localparam logic [SEC_W-1:0] SNOOZE_LAST = SEC_W'(SNOOZE_SECS - 1);
  localparam logic [1:0]       SNOOZE_LIM  = 2'(MAX_SNOOZE);

  alarm_state_t     state_q, state_d;
  logic [SEC_W-1:0] sec_cnt_q, sec_cnt_d;
  logic [1:0]       snooze_cnt_q, snooze_cnt_d;
  logic             match_q, match_d;
  logic             match_prev_q, match_prev_d;
  logic             buzzer_q, buzzer_d;
  logic             trigger;
  logic             tone;
  logic             ring_en;

  alarm_tone_gen #(
    .TONE_DIV(TONE_DIV)
  ) u_tone (
    .clk  (clk),
    .CLR_n(CLR_n),
    .en   (ring_en),
    .tone (tone)
  );

  // Only the 0->1 edge of the registered match fires, so a held time rings once.
  assign trigger = match_q && !match_prev_q;

  always_ff @(posedge clk or posedge CLR_n) begin
    if (CLR_n) begin
      state_q      <= IDLE;
      sec_cnt_q    <= '0;
      snooze_cnt_q <= '0;
      match_q      <= 1'b0;
      match_prev_q <= 1'b0;
      buzzer_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      sec_cnt_q    <= sec_cnt_d;
      snooze_cnt_q <= snooze_cnt_d;
      match_q      <= match_d;
      match_prev_q <= match_prev_d;
      buzzer_q     <= buzzer_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    sec_cnt_d    = sec_cnt_q;
    snooze_cnt_d = snooze_cnt_q;
    match_prev_d = match_q;
    match_d      = alarm_enable && !isSettingAlarm
                && bcd_hour_valid(alarm_hour_setting_tens, alarm_hour_setting_ones)
                && (cur_hour_tens == alarm_hour_setting_tens)
                && (cur_hour_ones == alarm_hour_setting_ones)
                && (cur_min_tens == BCD_ZERO) && (cur_min_ones == BCD_ZERO)
                && (cur_sec_tens == BCD_ZERO) && (cur_sec_ones == BCD_ZERO);

    // Disable outranks everything; then stop beats snooze, and buttons beat timeouts.
    if (!alarm_enable) begin
      state_d      = IDLE;
      sec_cnt_d    = '0;
      snooze_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (trigger) begin
            state_d      = RING;
            sec_cnt_d    = '0;
            snooze_cnt_d = '0;
          end
        end
        RING: begin
          if (stop_btn) begin
            state_d = IDLE;
          end else if (snooze_btn) begin
            if (snooze_cnt_q < SNOOZE_LIM) begin
              state_d      = SNOOZE;
              snooze_cnt_d = snooze_cnt_q + 2'd1;
              sec_cnt_d    = '0;
            end else begin
              state_d = IDLE;
            end
          end else if (sec_tick) begin
            if (sec_cnt_q == RING_LAST) begin
              state_d   = IDLE;
              sec_cnt_d = '0;
            end else begin
              sec_cnt_d = sec_cnt_q + SEC_W'(1);
            end
          end
        end
        SNOOZE: begin
          if (stop_btn) begin
            state_d = IDLE;
          end else if (sec_tick) begin
            if (sec_cnt_q == SNOOZE_LAST) begin
              state_d   = RING;
              sec_cnt_d = '0;
            end else begin
              sec_cnt_d = sec_cnt_q + SEC_W'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Beep only on even seconds of the ring period.
    buzzer_d = alarm_enable && (state_q == RING) && tone && !sec_cnt_q[0];
  end

  always_comb begin
    ringing    = (state_q == RING);
    snoozing   = (state_q == SNOOZE);
    ring_en    = (state_q == RING);
    snooze_cnt = snooze_cnt_q;
    buzzer     = buzzer_q;
  end

endmodule

// File: tb/tb_alarm_trigger.sv
// Scoreboard bench for alarm_trigger: expected status is queued as stimulus is
// driven and popped when the DUT response is sampled one step later.
module tb_alarm_trigger;

  localparam int TD = 4;
  localparam int RS = 60;
  localparam int SS = 300;
  localparam int MS = 3;

  typedef struct packed {
    logic       ringing;
    logic       snoozing;
    logic [1:0] cnt;
  } exp_t;

  logic       clk = 1'b0;
  logic       CLR_n;
  logic       sec_tick;
  logic [3:0] cur_hour_tens, cur_hour_ones, cur_min_tens, cur_min_ones;
  logic [3:0] cur_sec_tens, cur_sec_ones;
  logic [3:0] alarm_hour_setting_tens, alarm_hour_setting_ones;
  logic       alarm_enable, isSettingAlarm, stop_btn, snooze_btn;
  logic       buzzer, ringing, snoozing;
  logic [1:0] snooze_cnt;

  exp_t  exp_q[$];
  string name_q[$];
  exp_t  e, obs;
  string nm;
  int    checks = 0;
  int    passed = 0;

  alarm_trigger #(
    .TONE_DIV(TD), .RING_SECS(RS), .SNOOZE_SECS(SS), .MAX_SNOOZE(MS)
  ) dut (
    .clk(clk), .CLR_n(CLR_n), .sec_tick(sec_tick),
    .cur_hour_tens(cur_hour_tens), .cur_hour_ones(cur_hour_ones),
    .cur_min_tens(cur_min_tens), .cur_min_ones(cur_min_ones),
    .cur_sec_tens(cur_sec_tens), .cur_sec_ones(cur_sec_ones),
    .alarm_hour_setting_tens(alarm_hour_setting_tens),
    .alarm_hour_setting_ones(alarm_hour_setting_ones),
    .alarm_enable(alarm_enable), .isSettingAlarm(isSettingAlarm),
    .stop_btn(stop_btn), .snooze_btn(snooze_btn),
    .buzzer(buzzer), .ringing(ringing), .snoozing(snoozing), .snooze_cnt(snooze_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at time %0t, expected completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_time(input int h, input int m, input int s);
    cur_hour_tens = 4'(h / 10); cur_hour_ones = 4'(h % 10);
    cur_min_tens  = 4'(m / 10); cur_min_ones  = 4'(m % 10);
    cur_sec_tens  = 4'(s / 10); cur_sec_ones  = 4'(s % 10);
  endtask

  task automatic set_alarm(input int h);
    alarm_hour_setting_tens = 4'(h / 10);
    alarm_hour_setting_ones = 4'(h % 10);
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      sec_tick = 1'b1;
      step();
      sec_tick = 1'b0;
    end
  endtask

  task automatic expect_state(input string name, input logic r, input logic s, input logic [1:0] c);
    exp_q.push_back(exp_t'{r, s, c});
    name_q.push_back(name);
  endtask

  task automatic test_reset();
    expect_state("reset_state", 1'b0, 1'b0, 2'd0);
    repeat (3) step();
    e = exp_q.pop_front(); nm = name_q.pop_front(); obs = {ringing, snoozing, snooze_cnt}; checks++;
    if (obs !== e) $display("FAIL %s: got r=%b s=%b cnt=%0d, expected r=%b s=%b cnt=%0d", nm, obs.ringing, obs.snoozing, obs.cnt, e.ringing, e.snoozing, e.cnt);
    else passed++;
    checks++;
    if (buzzer !== 1'b0) $display("FAIL reset_buzzer: got %b, expected 0", buzzer);
    else passed++;
    CLR_n = 1'b0;
    step();
  endtask

  task automatic test_trigger_latency();
    set_alarm(7);
    alarm_enable = 1'b1;
    set_time(6, 59, 59);
    step(); step();
    set_time(7, 0, 0);
    expect_state("latency_1clk", 1'b0, 1'b0, 2'd0);
    expect_state("latency_2clk", 1'b1, 1'b0, 2'd0);
    for (int i = 0; i < 2; i++) begin
      step();
      e = exp_q.pop_front(); nm = name_q.pop_front(); obs = {ringing, snoozing, snooze_cnt}; checks++;
      if (obs !== e) $display("FAIL %s: got r=%b s=%b cnt=%0d, expected r=%b s=%b cnt=%0d", nm, obs.ringing, obs.snoozing, obs.cnt, e.ringing, e.snoozing, e.cnt);
      else passed++;
    end
  endtask

  task automatic test_tone();
    int n;
    n = 0;
    while (buzzer !== 1'b1 && n < 3 * TD) begin step(); n++; end
    checks++;
    if (buzzer !== 1'b1) $display("FAIL tone_start: buzzer got %b after %0d clks, expected 1", buzzer, n);
    else passed++;
    n = 0;
    while (buzzer === 1'b1 && n < 3 * TD) begin step(); n++; end
    checks++;
    if (n !== TD) $display("FAIL tone_high_len: got %0d clks, expected %0d", n, TD);
    else passed++;
    n = 0;
    while (buzzer === 1'b0 && n < 3 * TD) begin step(); n++; end
    checks++;
    if (n !== TD) $display("FAIL tone_low_len: got %0d clks, expected %0d", n, TD);
    else passed++;
    tick_n(1);
    step();
    n = 0;
    repeat (3 * TD) begin
      if (buzzer !== 1'b0) n++;
      step();
    end
    checks++;
    if (n !== 0) $display("FAIL odd_second_silent: buzzer high for %0d clks, expected 0", n);
    else passed++;
    tick_n(1);
    n = 0;
    while (buzzer !== 1'b1 && n < 3 * TD) begin step(); n++; end
    checks++;
    if (buzzer !== 1'b1) $display("FAIL even_second_beep: buzzer got %b, expected 1", buzzer);
    else passed++;
  endtask

  task automatic test_auto_stop();
    int n;
    tick_n(RS - 3);
    expect_state("ring_before_timeout", 1'b1, 1'b0, 2'd0);
    e = exp_q.pop_front(); nm = name_q.pop_front(); obs = {ringing, snoozing, snooze_cnt}; checks++;
    if (obs !== e) $display("FAIL %s: got r=%b s=%b cnt=%0d, expected r=%b s=%b cnt=%0d", nm, obs.ringing, obs.snoozing, obs.cnt, e.ringing, e.snoozing, e.cnt);
    else passed++;
    expect_state("auto_stop", 1'b0, 1'b0, 2'd0);
    tick_n(1);
    e = exp_q.pop_front(); nm = name_q.pop_front(); obs = {ringing, snoozing, snooze_cnt}; checks++;
    if (obs !== e) $display("FAIL %s: got r=%b s=%b cnt=%0d, expected r=%b s=%b cnt=%0d", nm, obs.ringing, obs.snoozing, obs.cnt, e.ringing, e.snoozing, e.cnt);
    else passed++;
    n = 0;
    repeat (5) begin
      step();
      if (ringing !== 1'b0 || buzzer !== 1'b0) n++;
    end
    checks++;
    if (n !== 0) $display("FAIL no_refire: active in %0d of 5 clks, expected 0", n);
    else passed++;
  endtask

  task automatic test_snooze();
    set_time(7, 0, 1); step(); step();
    set_time(7, 0, 0); step(); step();
    expect_state("resume_ring", 1'b1, 1'b0, 2'd0);
    e = exp_q.pop_front(); nm = name_q.pop_front(); obs = {ringing, snoozing, snooze_cnt}; checks++;
    if (obs !== e) $display("FAIL %s: got r=%b s=%b cnt=%0d, expected r=%b s=%b cnt=%0d", nm, obs.ringing, obs.snoozing, obs.cnt, e.ringing, e.snoozing, e.cnt);
    else passed++;
    for (int k = 1; k <= MS; k++) begin
      snooze_btn = 1'b1;
      expect_state("snooze_enter", 1'b0, 1'b1, 2'(k));
      step();
      snooze_btn = 1'b0;
      e = exp_q.pop_front(); nm = name_q.pop_front(); obs = {ringing, snoozing, snooze_cnt}; checks++;
      if (obs !== e) $display("FAIL %s: got r=%b s=%b cnt=%0d, expected r=%b s=%b cnt=%0d", nm, obs.ringing, obs.snoozing, obs.cnt, e.ringing, e.snoozing, e.cnt);
      else passed++;
      step();
      checks++;
      if (buzzer !== 1'b0) $display("FAIL snooze_buzzer_off: got %b, expected 0", buzzer);
      else passed++;
      if (k == 1) begin
        snooze_btn = 1'b1;
        expect_state("snooze_btn_ignored", 1'b0, 1'b1, 2'd1);
        step();
        snooze_btn = 1'b0;
        e = exp_q.pop_front(); nm = name_q.pop_front(); obs = {ringing, snoozing, snooze_cnt}; checks++;
        if (obs !== e) $display("FAIL %s: got r=%b s=%b cnt=%0d, expected r=%b s=%b cnt=%0d", nm, obs.ringing, obs.snoozing, obs.cnt, e.ringing, e.snoozing, e.cnt);
        else passed++;
      end
      tick_n(SS - 1);
      expect_state("snooze_hold", 1'b0, 1'b1, 2'(k));
      e = exp_q.pop_front(); nm = name_q.pop_front(); obs = {ringing, snoozing, snooze_cnt}; checks++;
      if (obs !== e) $display("FAIL %s: got r=%b s=%b cnt=%0d, expected r=%b s=%b cnt=%0d", nm, obs.ringing, obs.snoozing, obs.cnt, e.ringing, e.snoozing, e.cnt);
      else passed++;
      expect_state("snooze_wake", 1'b1, 1'b0, 2'(k));
      tick_n(1);
      e = exp_q.pop_front(); nm = name_q.pop_front(); obs = {ringing, snoozing, snooze_cnt}; checks++;
      if (obs !== e) $display("FAIL %s: got r=%b s=%b cnt=%0d, expected r=%b s=%b cnt=%0d", nm, obs.ringing, obs.snoozing, obs.cnt, e.ringing, e.snoozing, e.cnt);
      else passed++;
    end
    snooze_btn = 1'b1;
    expect_state("fourth_snooze_stops", 1'b0, 1'b0, 2'(MS));
    step();
    snooze_btn = 1'b0;
    e = exp_q.pop_front(); nm = name_q.pop_front(); obs = {ringing, snoozing, snooze_cnt}; checks++;
    if (obs !== e) $display("FAIL %s: got r=%b s=%b cnt=%0d, expected r=%b s=%b cnt=%0d", nm, obs.ringing, obs.snoozing, obs.cnt, e.ringing, e.snoozing, e.cnt);
    else passed++;
  endtask

  task automatic test_stop_and_snooze();
    set_time(7, 0, 1); step(); step();
    set_time(7, 0, 0); step(); step();
    expect_state("fresh_trigger_clears_cnt", 1'b1, 1'b0, 2'd0);
    e = exp_q.pop_front(); nm = name_q.pop_front(); obs = {ringing, snoozing, snooze_cnt}; checks++;
    if (obs !== e) $display("FAIL %s: got r=%b s=%b cnt=%0d, expected r=%b s=%b cnt=%0d", nm, obs.ringing, obs.snoozing, obs.cnt, e.ringing, e.snoozing, e.cnt);
    else passed++;
    snooze_btn = 1'b1;
    step();
    snooze_btn = 1'b0;
    tick_n(SS);
    expect_state("snooze_to_ring", 1'b1, 1'b0, 2'd1);
    e = exp_q.pop_front(); nm = name_q.pop_front(); obs = {ringing, snoozing, snooze_cnt}; checks++;
    if (obs !== e) $display("FAIL %s: got r=%b s=%b cnt=%0d, expected r=%b s=%b cnt=%0d", nm, obs.ringing, obs.snoozing, obs.cnt, e.ringing, e.snoozing, e.cnt);
    else passed++;
    stop_btn = 1'b1;
    snooze_btn = 1'b1;
    expect_state("stop_beats_snooze", 1'b0, 1'b0, 2'd1);
    step();
    stop_btn = 1'b0;
    snooze_btn = 1'b0;
    e = exp_q.pop_front(); nm = name_q.pop_front(); obs = {ringing, snoozing, snooze_cnt}; checks++;
    if (obs !== e) $display("FAIL %s: got r=%b s=%b cnt=%0d, expected r=%b s=%b cnt=%0d", nm, obs.ringing, obs.snoozing, obs.cnt, e.ringing, e.snoozing, e.cnt);
    else passed++;
  endtask

  task automatic test_suppress();
    set_time(7, 0, 1); step(); step();
    isSettingAlarm = 1'b1;
    set_time(7, 0, 0);
    expect_state("setting_suppress", 1'b0, 1'b0, 2'd1);
    repeat (4) step();
    e = exp_q.pop_front(); nm = name_q.pop_front(); obs = {ringing, snoozing, snooze_cnt}; checks++;
    if (obs !== e) $display("FAIL %s: got r=%b s=%b cnt=%0d, expected r=%b s=%b cnt=%0d", nm, obs.ringing, obs.snoozing, obs.cnt, e.ringing, e.snoozing, e.cnt);
    else passed++;
    set_time(7, 0, 1); step(); step();
    isSettingAlarm = 1'b0;
    set_alarm(25);
    set_time(25, 0, 0);
    expect_state("invalid_alarm_hour", 1'b0, 1'b0, 2'd1);
    repeat (4) step();
    e = exp_q.pop_front(); nm = name_q.pop_front(); obs = {ringing, snoozing, snooze_cnt}; checks++;
    if (obs !== e) $display("FAIL %s: got r=%b s=%b cnt=%0d, expected r=%b s=%b cnt=%0d", nm, obs.ringing, obs.snoozing, obs.cnt, e.ringing, e.snoozing, e.cnt);
    else passed++;
    set_alarm(7);
    set_time(7, 0, 1); step(); step();
  endtask

  task automatic test_enable_drop();
    set_time(7, 0, 0); step(); step();
    snooze_btn = 1'b1;
    expect_state("enable_test_snooze", 1'b0, 1'b1, 2'd1);
    step();
    snooze_btn = 1'b0;
    e = exp_q.pop_front(); nm = name_q.pop_front(); obs = {ringing, snoozing, snooze_cnt}; checks++;
    if (obs !== e) $display("FAIL %s: got r=%b s=%b cnt=%0d, expected r=%b s=%b cnt=%0d", nm, obs.ringing, obs.snoozing, obs.cnt, e.ringing, e.snoozing, e.cnt);
    else passed++;
    tick_n(10);
    alarm_enable = 1'b0;
    expect_state("enable_drop", 1'b0, 1'b0, 2'd0);
    step();
    e = exp_q.pop_front(); nm = name_q.pop_front(); obs = {ringing, snoozing, snooze_cnt}; checks++;
    if (obs !== e) $display("FAIL %s: got r=%b s=%b cnt=%0d, expected r=%b s=%b cnt=%0d", nm, obs.ringing, obs.snoozing, obs.cnt, e.ringing, e.snoozing, e.cnt);
    else passed++;
    checks++;
    if (buzzer !== 1'b0) $display("FAIL enable_drop_buzzer: got %b, expected 0", buzzer);
    else passed++;
    set_time(7, 0, 1);
    alarm_enable = 1'b1;
    step(); step();
  endtask

  task automatic test_reset_midring();
    int n;
    set_time(7, 0, 0); step(); step();
    n = 0;
    while (buzzer !== 1'b1 && n < 3 * TD) begin step(); n++; end
    checks++;
    if (buzzer !== 1'b1) $display("FAIL buzzer_before_reset: got %b, expected 1", buzzer);
    else passed++;
    #2;
    CLR_n = 1'b1;
    #1;
    expect_state("async_reset", 1'b0, 1'b0, 2'd0);
    e = exp_q.pop_front(); nm = name_q.pop_front(); obs = {ringing, snoozing, snooze_cnt}; checks++;
    if (obs !== e) $display("FAIL %s: got r=%b s=%b cnt=%0d, expected r=%b s=%b cnt=%0d", nm, obs.ringing, obs.snoozing, obs.cnt, e.ringing, e.snoozing, e.cnt);
    else passed++;
    checks++;
    if (buzzer !== 1'b0) $display("FAIL async_reset_buzzer: got %b, expected 0", buzzer);
    else passed++;
    set_alarm(23);
    set_time(22, 59, 59);
    #1;
    CLR_n = 1'b0;
    step(); step();
    set_time(23, 0, 0);
    expect_state("alarm_23_wait", 1'b0, 1'b0, 2'd0);
    expect_state("alarm_23_rings", 1'b1, 1'b0, 2'd0);
    for (int i = 0; i < 2; i++) begin
      step();
      e = exp_q.pop_front(); nm = name_q.pop_front(); obs = {ringing, snoozing, snooze_cnt}; checks++;
      if (obs !== e) $display("FAIL %s: got r=%b s=%b cnt=%0d, expected r=%b s=%b cnt=%0d", nm, obs.ringing, obs.snoozing, obs.cnt, e.ringing, e.snoozing, e.cnt);
      else passed++;
    end
  endtask

  initial begin
    CLR_n = 1'b0;
    sec_tick = 1'b0;
    stop_btn = 1'b0;
    snooze_btn = 1'b0;
    alarm_enable = 1'b0;
    isSettingAlarm = 1'b0;
    set_time(0, 0, 1);
    set_alarm(7);
    #1;
    CLR_n = 1'b1;
    $display("[TB] starting alarm_trigger bench");
    test_reset();
    test_trigger_latency();
    test_tone();
    test_auto_stop();
    test_snooze();
    test_stop_and_snooze();
    test_suppress();
    test_enable_drop();
    test_reset_midring();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
